// File: rtl/fetch_stage.sv
// fetch_stage: IF stage of the 5-stage RV64 pipeline.
// Owns the PC, keeps at most one instruction-bus request in flight, feeds the
// IF/ID register and follows the hazard unit (stall holds IF/ID, redirect
// flushes it). Responses that belong to a request overtaken by a redirect are
// dropped.
// Optional build macro: FETCH_PERF_EN enables the perf_fetched/perf_discard
// counters; without it both ports are tied to zero.
module fetch_stage #(
  parameter int unsigned     XLEN     = 64,
  parameter int unsigned     INSTR_W  = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h8000_0000)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               redirect,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               ireq_valid,
  output logic [XLEN-1:0]    ireq_addr,
  input  logic               iresp_ok,
  input  logic [INSTR_W-1:0] iresp_data,
  output logic               dec_valid,
  output logic [XLEN-1:0]    dec_pc,
  output logic [INSTR_W-1:0] dec_instr,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_discard
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD,
    DISCARD
  } fetchState_t;

  fetchState_t        state;
  fetchState_t        stateNext;

  logic [XLEN-1:0]    pc;
  logic [XLEN-1:0]    staleAddr;
  logic [XLEN-1:0]    skidPc;
  logic [INSTR_W-1:0] skidInstr;

  logic               inReq;
  logic               inHold;
  logic               inDiscard;
  logic               deliverNow;
  logic               dropNow;

  assign inReq     = (state == REQ);
  assign inHold    = (state == HOLD);
  assign inDiscard = (state == DISCARD);

  // An instruction reaches IF/ID either straight from the bus or from the skid.
  assign deliverNow = !redirect && !stall && ((inReq && iresp_ok) || inHold);
  // A bus response is thrown away when a redirect overtakes it.
  assign dropNow    = (inReq && iresp_ok && redirect) || (inDiscard && iresp_ok);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state selection; redirect outranks stall in every state.
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: stateNext = REQ;
      REQ: begin
        if (redirect) begin
          // Without the response in hand the bus transaction must still be
          // completed (no cancellation), so it is waited out in DISCARD.
          stateNext = iresp_ok ? REQ : DISCARD;
        end else if (iresp_ok) begin
          stateNext = stall ? HOLD : REQ;
        end
      end
      HOLD: begin
        if (redirect || !stall) begin
          stateNext = REQ;
        end
      end
      DISCARD: begin
        if (iresp_ok) begin
          stateNext = REQ;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Bus request outputs; DISCARD keeps presenting the overtaken address.
  always_comb begin
    ireq_valid = inReq || inDiscard;
    ireq_addr  = inDiscard ? staleAddr : pc;
  end

  // PC, stale-address latch and skid buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc        <= RESET_PC;
      staleAddr <= '0;
      skidPc    <= '0;
      skidInstr <= '0;
    end else begin
      if (redirect) begin
        pc <= redirect_pc;
      end else if (inReq && iresp_ok) begin
        pc <= pc + XLEN'(4);
      end
      if (inReq && redirect && !iresp_ok) begin
        staleAddr <= pc;
      end
      if (inReq && iresp_ok && stall && !redirect) begin
        skidPc    <= pc;
        skidInstr <= iresp_data;
      end
    end
  end

  // IF/ID register: flush on redirect, freeze on stall, otherwise load or bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dec_valid <= 1'b0;
      dec_pc    <= '0;
      dec_instr <= '0;
    end else if (redirect) begin
      dec_valid <= 1'b0;
    end else if (!stall) begin
      if (inReq && iresp_ok) begin
        dec_valid <= 1'b1;
        dec_pc    <= pc;
        dec_instr <= iresp_data;
      end else if (inHold) begin
        dec_valid <= 1'b1;
        dec_pc    <= skidPc;
        dec_instr <= skidInstr;
      end else begin
        dec_valid <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] fetchedCnt;
  logic [31:0] discardCnt;

  // Delivered / dropped instruction counters, free-running with wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetchedCnt <= '0;
      discardCnt <= '0;
    end else begin
      if (deliverNow) begin
        fetchedCnt <= fetchedCnt + 32'd1;
      end
      if (dropNow) begin
        discardCnt <= discardCnt + 32'd1;
      end
    end
  end

  assign perf_fetched = fetchedCnt;
  assign perf_discard = discardCnt;
`else
  logic unusedPerf;
  assign unusedPerf   = deliverNow ^ dropNow;
  assign perf_fetched = '0;
  assign perf_discard = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized bench for fetch_stage with a transaction-level
// reference model (pending request / skid slot / stale wait) and a small
// ibus responder with configurable latency.
module tb_fetch_stage;

  localparam int unsigned XLEN    = 64;
  localparam int unsigned INSTR_W = 32;
  localparam logic [63:0] RST_PC  = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_ok = 1'b0;
  logic [31:0] iresp_data = '0;
  logic        dec_valid;
  logic [63:0] dec_pc;
  logic [31:0] dec_instr;
  logic [31:0] perf_fetched;
  logic [31:0] perf_discard;

  always #5 clk = ~clk;

  fetch_stage #(
    .XLEN    (XLEN),
    .INSTR_W (INSTR_W),
    .RESET_PC(RST_PC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .ireq_valid  (ireq_valid),
    .ireq_addr   (ireq_addr),
    .iresp_ok    (iresp_ok),
    .iresp_data  (iresp_data),
    .dec_valid   (dec_valid),
    .dec_pc      (dec_pc),
    .dec_instr   (dec_instr),
    .perf_fetched(perf_fetched),
    .perf_discard(perf_discard)
  );

  int nChecks = 0;
  int nErrors = 0;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: what the fetch unit is doing, in transaction terms.
  logic        mStarted;
  logic        mWaitStale;
  logic        mSkidFull;
  logic [63:0] mPc;
  logic [63:0] mStaleAddr;
  logic [63:0] mSkidPc;
  logic [31:0] mSkidInstr;
  logic        mDecV;
  logic [63:0] mDecPc;
  logic [31:0] mDecInstr;
  logic [31:0] mFetched;
  logic [31:0] mDiscard;

  task automatic modelReset();
    mStarted   = 1'b0;
    mWaitStale = 1'b0;
    mSkidFull  = 1'b0;
    mPc        = RST_PC;
    mStaleAddr = '0;
    mSkidPc    = '0;
    mSkidInstr = '0;
    mDecV      = 1'b0;
    mDecPc     = '0;
    mDecInstr  = '0;
    mFetched   = '0;
    mDiscard   = '0;
  endtask

  task automatic modelStep();
    logic [63:0] oldPc;
    oldPc = mPc;
    if (!mStarted) begin
      mStarted = 1'b1;
      if (redirect) mPc = redirect_pc;
      if (redirect || !stall) mDecV = 1'b0;
    end else if (mSkidFull) begin
      if (redirect) begin
        mSkidFull = 1'b0;
        mPc       = redirect_pc;
        mDecV     = 1'b0;
      end else if (!stall) begin
        mSkidFull = 1'b0;
        mDecV     = 1'b1;
        mDecPc    = mSkidPc;
        mDecInstr = mSkidInstr;
        mFetched++;
      end
    end else if (mWaitStale) begin
      if (redirect) mPc = redirect_pc;
      if (iresp_ok) begin
        mWaitStale = 1'b0;
        mDiscard++;
      end
      if (redirect || !stall) mDecV = 1'b0;
    end else begin
      if (redirect) begin
        mDecV = 1'b0;
        mPc   = redirect_pc;
        if (iresp_ok) begin
          mDiscard++;
        end else begin
          mWaitStale = 1'b1;
          mStaleAddr = oldPc;
        end
      end else if (iresp_ok) begin
        if (stall) begin
          mSkidFull  = 1'b1;
          mSkidPc    = oldPc;
          mSkidInstr = iresp_data;
        end else begin
          mDecV     = 1'b1;
          mDecPc    = oldPc;
          mDecInstr = iresp_data;
          mFetched++;
        end
        mPc = oldPc + 64'd4;
      end else if (!stall) begin
        mDecV = 1'b0;
      end
    end
  endtask

  task automatic checkOutputs();
    logic        expValid;
    logic [63:0] expAddr;
    logic [31:0] expF;
    logic [31:0] expD;
    expValid = mStarted && !mSkidFull;
    expAddr  = mWaitStale ? mStaleAddr : mPc;
`ifdef FETCH_PERF_EN
    expF = mFetched;
    expD = mDiscard;
`else
    expF = '0;
    expD = '0;
`endif
    checkVal("ireqValid", 64'(ireq_valid), 64'(expValid));
    if (expValid) checkVal("ireqAddr", ireq_addr, expAddr);
    checkVal("decValid", 64'(dec_valid), 64'(mDecV));
    if (mDecV) begin
      checkVal("decPc", dec_pc, mDecPc);
      checkVal("decInstr", 64'(dec_instr), 64'(mDecInstr));
    end
    checkVal("perfFetched", 64'(perf_fetched), 64'(expF));
    checkVal("perfDiscard", 64'(perf_discard), 64'(expD));
  endtask

  // ibus responder: accepts a request when idle, answers after busLat cycles
  // (busLat==0 picks 1..4 at random per request).
  logic        busBusy = 1'b0;
  int unsigned busWait = 0;
  logic [63:0] busAddr = '0;
  int unsigned busLat = 1;
  logic        busFixedData = 1'b1;

  task automatic busReset();
    busBusy  = 1'b0;
    busWait  = 0;
    iresp_ok = 1'b0;
  endtask

  task automatic busAdvance();
    if (iresp_ok) begin
      busBusy  = 1'b0;
      iresp_ok = 1'b0;
    end
    if (busBusy) begin
      checkVal("busHoldValid", 64'(ireq_valid), 64'd1);
      checkVal("busHoldAddr", ireq_addr, busAddr);
      busWait--;
      if (busWait == 0) begin
        iresp_ok   = 1'b1;
        iresp_data = busFixedData ? 32'h0000_0013 : $urandom;
      end
    end else if (ireq_valid) begin
      busBusy = 1'b1;
      busAddr = ireq_addr;
      busWait = (busLat == 0) ? $urandom_range(4, 1) : busLat;
    end
  endtask

  // One clock: model consumes the inputs seen at the edge, outputs are
  // compared just after it, then the responder plans the next cycle.
  task automatic cycle();
    @(posedge clk);
    modelStep();
    #1;
    checkOutputs();
    busAdvance();
  endtask

  task automatic doReset(input int unsigned n);
    reset    = 1'b1;
    stall    = 1'b0;
    redirect = 1'b0;
    busReset();
    modelReset();
    repeat (n) @(posedge clk);
    #1;
    checkVal("rstIreqValid", 64'(ireq_valid), 64'd0);
    checkVal("rstDecValid", 64'(dec_valid), 64'd0);
    checkVal("rstDecPc", dec_pc, 64'd0);
    checkVal("rstDecInstr", 64'(dec_instr), 64'd0);
    checkVal("rstPerfFetched", 64'(perf_fetched), 64'd0);
    checkVal("rstPerfDiscard", 64'(perf_discard), 64'd0);
    reset = 1'b0;
  endtask

  task automatic waitResp(input string tag);
    logic found;
    found = iresp_ok;
    for (int k = 0; k < 12 && !found; k++) begin
      cycle();
      found = iresp_ok;
    end
    checkVal(tag, 64'(found), 64'd1);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin : stimulus
    logic found;

    // Straight-line fetch with one-cycle bus latency.
    busLat       = 1;
    busFixedData = 1'b1;
    doReset(2);
    cycle();
    checkVal("t1Addr0", ireq_addr, 64'h8000_0000);
    cycle();
    cycle();
    checkVal("t1Dec0Valid", 64'(dec_valid), 64'd1);
    checkVal("t1Dec0Pc", dec_pc, 64'h8000_0000);
    checkVal("t1Addr1", ireq_addr, 64'h8000_0004);

    // Stall while the response for 8000_0004 arrives.
    found = iresp_ok && (ireq_addr == 64'h8000_0004);
    for (int k = 0; k < 8 && !found; k++) begin
      cycle();
      found = iresp_ok && (ireq_addr == 64'h8000_0004);
    end
    checkVal("t2RespSeen", 64'(found), 64'd1);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      checkVal("t2HoldReqOff", 64'(ireq_valid), 64'd0);
      checkVal("t2HoldDecPc", dec_pc, 64'h8000_0000);
    end
    stall  = 1'b0;
    busLat = 4;
    cycle();
    checkVal("t2ReleaseValid", 64'(dec_valid), 64'd1);
    checkVal("t2ReleasePc", dec_pc, 64'h8000_0004);
    checkVal("t2NextAddr", ireq_addr, 64'h8000_0008);

    // Redirect while the 8000_0008 request is still waiting.
    redirect    = 1'b1;
    redirect_pc = 64'h8000_0100;
    cycle();
    redirect = 1'b0;
    found    = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      cycle();
      checkVal("t3Bubble", 64'(dec_valid), 64'd0);
      found = ireq_valid && (ireq_addr == 64'h8000_0100);
      if (ireq_valid && !found) checkVal("t3StaleAddr", ireq_addr, 64'h8000_0008);
    end
    checkVal("t3NewTarget", 64'(found), 64'd1);

    // Redirect, response and stall all in one cycle.
    waitResp("t4RespSeen");
    redirect    = 1'b1;
    stall       = 1'b1;
    redirect_pc = 64'h8000_0200;
    cycle();
    redirect = 1'b0;
    stall    = 1'b0;
    checkVal("t4DecFlushed", 64'(dec_valid), 64'd0);
    checkVal("t4ReqValid", 64'(ireq_valid), 64'd1);
    checkVal("t4ReqAddr", ireq_addr, 64'h8000_0200);

    // PC wrap at the top of the address space.
    busLat = 1;
    waitResp("t5RespSeen");
    redirect    = 1'b1;
    redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    cycle();
    redirect = 1'b0;
    found    = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      cycle();
      found = ireq_valid && (ireq_addr == 64'd0);
    end
    checkVal("t5WrapToZero", 64'(found), 64'd1);
    checkVal("t5DecPc", dec_pc, 64'hFFFF_FFFF_FFFF_FFFC);

    // Asynchronous reset in the middle of a discard.
    busLat = 4;
    found  = busBusy && !iresp_ok && (busWait >= 3);
    for (int k = 0; k < 12 && !found; k++) begin
      cycle();
      found = busBusy && !iresp_ok && (busWait >= 3);
    end
    checkVal("t6FreshReq", 64'(found), 64'd1);
    redirect    = 1'b1;
    redirect_pc = 64'h0000_0000_0001_0000;
    cycle();
    redirect = 1'b0;
    cycle();
    #2;
    reset = 1'b1;
    #1;
    checkVal("t6AsyncReqOff", 64'(ireq_valid), 64'd0);
    checkVal("t6AsyncDecOff", 64'(dec_valid), 64'd0);
    checkVal("t6AsyncPerfF", 64'(perf_fetched), 64'd0);
    checkVal("t6AsyncPerfD", 64'(perf_discard), 64'd0);
    doReset(2);
    cycle();
    checkVal("t6FirstReqValid", 64'(ireq_valid), 64'd1);
    checkVal("t6FirstReqAddr", ireq_addr, RST_PC);

    // Randomized traffic against the model.
    busLat       = 0;
    busFixedData = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) doReset(1);
      stall    = ($urandom_range(3, 0) == 0);
      redirect = ($urandom_range(9, 0) == 0);
      if ($urandom_range(7, 0) == 0) begin
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(3, 0) * 4);
      end else begin
        redirect_pc = {$urandom, $urandom} & ~64'd3;
      end
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
